div_result_fifo: RTL

//  Read side of the divider datapath. The controller pulses ld_result when a division completes.

---
 rtl/div_pkg.sv | 12 +
 rtl/wrap_ptr.sv | 26 ++
 rtl/div_result_fifo.sv | 97 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types for the divider result path.
package div_pkg;

  localparam int DIV_DATA_W = 16;

  typedef struct packed {
    logic [DIV_DATA_W-1:0] quo;
    logic [DIV_DATA_W-1:0] rem;
    logic                  dbz;
  } div_result_t;

endpackage

// File: rtl/wrap_ptr.sv
// Modulo-DEPTH pointer with increment enable and async active-low reset.
module wrap_ptr #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/div_result_fifo.sv
// Result FIFO between the divider datapath and its consumer; first-word
// fall-through read, sticky overflow when a push arrives while full.
module div_result_fifo
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int DEPTH  = 4,
  parameter int PW     = $clog2(DEPTH),
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_result,
  input  logic [DATA_W-1:0] quotient_in,
  input  logic [DATA_W-1:0] remainder_in,
  input  logic              dbz_in,
  output logic              full,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient_out,
  output logic [DATA_W-1:0] remainder_out,
  output logic              dbz_out,
  output logic [CW-1:0]     count,
  output logic              overflow,
  input  logic              clr_overflow
);

  div_result_t   r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  logic          w_push;
  logic          w_pop;
  div_result_t   w_head;

  assign out_valid = (r_count != '0);
  assign full      = (r_count == CW'(DEPTH));
  assign w_pop     = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push    = ld_result & (~full | w_pop);

  wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_push),
    .o_ptr (w_wr_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_pop),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[w_wr_ptr] <= '{quo: quotient_in, rem: remainder_in, dbz: dbz_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Set has priority over clear so a drop is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (ld_result & full & ~w_pop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_head        = r_mem[w_rd_ptr];
  assign quotient_out  = w_head.quo;
  assign remainder_out = w_head.rem;
  assign dbz_out       = w_head.dbz;
  assign count         = r_count;
  assign overflow      = r_overflow;

endmodule
